// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sequencer
// Brief    : Round-robin arbiter that expands key events into PS/2 Set-2 bytes
//            ([E0] [F0] code), one key_action strobe per byte, gap-paced.
// Revision : 1.0
// ============================================================================
module ps2_key_sequencer #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_ext,
    input  logic [NUM_REQ-1:0]     req_brk,
    input  logic [8*NUM_REQ-1:0]   req_code,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   key_action,
    output logic [7:0]             scan_code,
    output logic                   busy
);

    localparam int           c_PTR_W    = $clog2(NUM_REQ);
    localparam logic [7:0]   c_GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_E0   = 3'd1,
        S_SEND_F0   = 3'd2,
        S_SEND_CODE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    state_t               r_prev;
    state_t               w_sent;
    state_t               w_follow;
    state_t               w_first;
    logic [c_PTR_W-1:0]   r_ptr;
    logic                 r_brk;
    logic [7:0]           r_code;
    logic [7:0]           r_gap_cnt;

    logic                 w_any;
    logic [c_PTR_W-1:0]   w_win;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic                 w_grant;
    logic                 w_win_ext;
    logic                 w_win_brk;
    logic [7:0]           w_win_code;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[idx[c_PTR_W-1:0]]) begin
                w_any = 1'b1;
                w_win = idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_win_oh   = NUM_REQ'(1) << w_win;
    assign w_win_ext  = req_ext[w_win];
    assign w_win_brk  = req_brk[w_win];
    assign w_win_code = req_code[{w_win, 3'b000} +: 8];
    assign w_grant    = (r_state == S_IDLE) && w_any;

    assign w_first = w_win_ext ? S_SEND_E0 : (w_win_brk ? S_SEND_F0 : S_SEND_CODE);

    // The byte just issued decides what follows; during GAP it is held in r_prev.
    always_comb begin
        w_sent   = (r_state == S_GAP) ? r_prev : r_state;
        w_follow = S_IDLE;
        case (w_sent)
            S_SEND_E0: w_follow = r_brk ? S_SEND_F0 : S_SEND_CODE;
            S_SEND_F0: w_follow = S_SEND_CODE;
            default:   w_follow = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        key_action  = 1'b0;
        scan_code   = 8'h00;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    gnt         = Resetn ? w_win_oh : '0;
                    w_state_nxt = w_first;
                end
            end
            S_SEND_E0, S_SEND_F0, S_SEND_CODE: begin
                key_action  = 1'b1;
                scan_code   = (r_state == S_SEND_E0) ? 8'hE0 :
                              (r_state == S_SEND_F0) ? 8'hF0 : r_code;
                w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : w_follow;
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = w_follow;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_ptr     <= '0;
            r_brk     <= 1'b0;
            r_code    <= 8'h00;
            r_gap_cnt <= 8'h00;
            r_prev    <= S_IDLE;
        end else begin
            if (w_grant) begin
                r_brk  <= w_win_brk;
                r_code <= w_win_code;
                r_ptr  <= (w_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            if (r_state == S_SEND_E0 || r_state == S_SEND_F0 || r_state == S_SEND_CODE) begin
                r_prev    <= r_state;
                r_gap_cnt <= 8'h00;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'h01;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_sequencer
// Brief    : Directed and randomized bench against an event-level byte model.
// Revision : 1.0
// ============================================================================
module tb_ps2_key_sequencer;

    localparam int N   = 4;
    localparam int GAP = 2;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_ext = '0;
    logic [N-1:0]     req_brk = '0;
    logic [8*N-1:0]   req_code = '0;
    logic [N-1:0]     gnt;
    logic             key_action;
    logic [7:0]       scan_code;
    logic             busy;

    always #5 Clock = ~Clock;

    ps2_key_sequencer #(.NUM_REQ(N), .GAP_CYCLES(GAP)) u_dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req        (req),
        .req_ext    (req_ext),
        .req_brk    (req_brk),
        .req_code   (req_code),
        .gnt        (gnt),
        .key_action (key_action),
        .scan_code  (scan_code),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester-side stimulus state
    bit          pend   [N];
    bit          s_ext  [N];
    bit          s_brk  [N];
    logic [7:0]  s_code [N];
    bit          rstn_v = 1'b0;
    bit          hold   = 1'b0;
    bit          rmode  = 1'b0;

    // Event-level reference: remaining busy cycles plus the byte list of the event
    int          m_rem   = 0;
    int          m_total = 0;
    int          m_ptr   = 0;
    int          m_n     = 0;
    logic [7:0]  m_bytes [3];
    int          last_win = -1;

    logic [7:0]  seen [$];
    int          glog [$];

    task automatic drive();
        @(posedge Clock);
        #1;
        if (last_win >= 0 && !hold) pend[last_win] = 1'b0;
        if (rmode) begin
            rstn_v = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i]  = 1'b1;
                        s_ext[i] = 1'($urandom_range(0, 1));
                        s_brk[i] = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 9))
                            0:       s_code[i] = 8'hE0;
                            1:       s_code[i] = 8'hF0;
                            default: s_code[i] = 8'($urandom);
                        endcase
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        Resetn = rstn_v;
        for (int i = 0; i < N; i++) begin
            req[i]            = pend[i];
            req_ext[i]        = s_ext[i];
            req_brk[i]        = s_brk[i];
            req_code[8*i +: 8] = s_code[i];
        end
    endtask

    task automatic step();
        logic [N-1:0] e_gnt;
        logic         e_ka;
        logic [7:0]   e_sc;
        logic         e_busy;
        int           win;
        int           p;
        @(negedge Clock);
        e_gnt = '0; e_ka = 1'b0; e_sc = 8'h00; e_busy = 1'b0; win = -1;
        if (m_rem > 0) begin
            e_busy = 1'b1;
            p = m_total - m_rem;
            if (p % (GAP + 1) == 0) begin
                e_ka = 1'b1;
                e_sc = m_bytes[p / (GAP + 1)];
            end
        end else if (Resetn) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) e_gnt[win] = 1'b1;
        end
        chk("gnt",        32'(gnt),        32'(e_gnt));
        chk("key_action", 32'(key_action), 32'(e_ka));
        chk("scan_code",  32'(scan_code),  32'(e_sc));
        chk("busy",       32'(busy),       32'(e_busy));
        if (key_action) seen.push_back(scan_code);
        for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);

        if (!Resetn) begin
            m_rem = 0;
            m_ptr = 0;
        end else if (win >= 0) begin
            m_n = 0;
            if (req_ext[win]) begin m_bytes[m_n] = 8'hE0; m_n++; end
            if (req_brk[win]) begin m_bytes[m_n] = 8'hF0; m_n++; end
            m_bytes[m_n] = req_code[8*win +: 8];
            m_n++;
            m_total = m_n * (GAP + 1);
            m_rem   = m_total;
            m_ptr   = (win + 1) % N;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        last_win = win;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            step();
        end
    endtask

    task automatic set_req(input int i, input bit e, input bit b, input logic [7:0] c);
        pend[i] = 1'b1; s_ext[i] = e; s_brk[i] = b; s_code[i] = c;
    endtask

    task automatic clear_logs();
        seen.delete();
        glog.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; s_ext[i] = 1'b0; s_brk[i] = 1'b0; s_code[i] = 8'h00;
        end

        // Reset held with every requester asking
        rstn_v = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'(8'h40 + i));
        run(3);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rstn_v = 1'b1;
        run(2);

        // Plain make
        clear_logs();
        set_req(0, 1'b0, 1'b0, 8'h1C);
        run(8);
        chk("plain_nbytes", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) chk("plain_byte", 32'(seen[0]), 32'h1C);
        if (glog.size() >= 1) chk("plain_gnt", 32'(glog[0]), 32'd0);

        // Extended break
        clear_logs();
        set_req(1, 1'b1, 1'b1, 8'h74);
        run(13);
        chk("extbrk_nbytes", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("extbrk_b0", 32'(seen[0]), 32'hE0);
            chk("extbrk_b1", 32'(seen[1]), 32'hF0);
            chk("extbrk_b2", 32'(seen[2]), 32'h74);
        end

        // Round robin from a freshly reset pointer, all requests held
        rstn_v = 1'b0;
        run(1);
        rstn_v = 1'b1;
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'(8'h10 + i));
        run(24);
        hold = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        run(6);
        chk("rr_ngrants", 32'(glog.size()), 32'd6);
        if (glog.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 32'(glog[i]), 32'(i % N));
        end

        // Request raised during the F0 gap
        clear_logs();
        set_req(1, 1'b1, 1'b1, 8'h5A);
        run(5);
        set_req(2, 1'b0, 1'b0, 8'h29);
        run(15);
        chk("busyreq_nbytes", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("busyreq_code1", 32'(seen[2]), 32'h5A);
            chk("busyreq_code2", 32'(seen[3]), 32'h29);
        end
        chk("busyreq_ngnt", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("busyreq_gnt2", 32'(glog[1]), 32'd2);

        // Reset one cycle after the E0 byte
        clear_logs();
        set_req(1, 1'b1, 1'b1, 8'h6B);
        run(2);
        rstn_v = 1'b0;
        set_req(3, 1'b0, 1'b0, 8'h33);
        set_req(0, 1'b0, 1'b0, 8'h45);
        run(1);
        rstn_v = 1'b1;
        run(12);
        chk("midrst_nbytes", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("midrst_b0", 32'(seen[0]), 32'hE0);
            chk("midrst_b1", 32'(seen[1]), 32'h45);
            chk("midrst_b2", 32'(seen[2]), 32'h33);
        end
        chk("midrst_ngnt", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) chk("midrst_first", 32'(glog[1]), 32'd0);

        // Randomized traffic with occasional resets and withdrawals
        rmode = 1'b1;
        run(1500);
        rmode  = 1'b0;
        rstn_v = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
